// File: rtl/mdu_core.sv
// mdu_core: multi-cycle multiply/divide unit with HI/LO result registers.
// MULT/MULTU/DIV/DIVU take a fixed number of busy cycles; MTHI/MTLO write in one cycle.
// Optional macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (ops 6-9) accumulating into {hi,lo}.
module mdu_core #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nxt;
   logic              accept, finish;
   logic [CW-1:0]     count;
   logic [3:0]        op_q;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [WIDTH-1:0]  res_hi, res_lo;

   // True for operations that occupy the unit for several cycles
   function automatic logic is_long(input logic [3:0] code);
      logic r;
      case (code)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Initial counter value: divides use the divide latency, everything else the multiply latency
   function automatic logic [CW-1:0] latency(input logic [3:0] code);
      logic [CW-1:0] r;
      if (code == OP_DIV || code == OP_DIVU) r = CW'(DIV_CYCLES - 1);
      else                                   r = CW'(MUL_CYCLES - 1);
      return r;
   endfunction

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, accept/finish strobes and busy
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start && is_long(op)) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (count == '0) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // Result of the latched operation, computed from latched operands and current hi/lo
   always_comb begin
      logic [2*WIDTH-1:0]        prod_s, prod_u;
      logic signed [WIDTH-1:0]   sa, sb;
      logic                      ovf;
`ifdef MDU_MADD_EN
      logic [2*WIDTH-1:0]        acc;
      acc = {hi, lo};
`endif
      res_hi = hi;
      res_lo = lo;
      prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
      prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      ovf    = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
      sa     = a_q;
      sb     = (b_q == '0 || ovf) ? WIDTH'(1) : b_q;
      case (op_q)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            if (b_q == '0) begin
               res_hi = hi;
               res_lo = lo;
            end else if (ovf) begin
               res_hi = '0;
               res_lo = a_q;
            end else begin
               res_lo = sa / sb;
               res_hi = sa % sb;
            end
         end
         OP_DIVU: begin
            if (b_q != '0) begin
               res_lo = a_q / b_q;
               res_hi = a_q % b_q;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {res_hi, res_lo} = acc + prod_s;
         OP_MADDU: {res_hi, res_lo} = acc + prod_u;
         OP_MSUB:  {res_hi, res_lo} = acc - prod_s;
         OP_MSUBU: {res_hi, res_lo} = acc - prod_u;
`endif
         default: begin
            res_hi = hi;
            res_lo = lo;
         end
      endcase
   end

   // Operand latch, latency counter, done pulse and HI/LO registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= finish;
         if (accept) begin
            op_q  <= op;
            a_q   <= op1;
            b_q   <= op2;
            count <= latency(op);
         end else if (state == RUN && count != '0) begin
            count <= count - 1'b1;
         end
         if (finish) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == IDLE && start) begin
            if (op == OP_MTHI) hi <= op1;
            if (op == OP_MTLO) lo <= op1;
         end
      end
   end

endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: directed and random checks of mdu_core against an arithmetic reference model.
module tb_mdu_core;

   localparam int W    = 32;
   localparam int MULC = 5;
   localparam int DIVC = 10;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    op    = 4'd0;
   logic [W-1:0]  op1   = '0;
   logic [W-1:0]  op2   = '0;
   logic          busy, done;
   logic [W-1:0]  hi, lo;

   int            total = 0;
   int            bad   = 0;
   logic [W-1:0]  mhi   = '0;
   logic [W-1:0]  mlo   = '0;

   mdu_core #(.WIDTH(W), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .op1   (op1),
      .op2   (op2),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: what {hi,lo} become after the given op completes
   function automatic void modelOp(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
      longint        sp;
      logic [63:0]   up, acc;
      int            sa, sb;
      sa  = a;
      sb  = b;
      sp  = longint'(sa) * longint'(sb);
      up  = {32'b0, a} * {32'b0, b};
      acc = {mhi, mlo};
      case (code)
         4'd0: {mhi, mlo} = sp;
         4'd1: {mhi, mlo} = up;
         4'd2: begin
            if (b == 0) begin
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               mlo = a;
               mhi = 32'd0;
            end else begin
               mlo = sa / sb;
               mhi = sa % sb;
            end
         end
         4'd3: begin
            if (b != 0) begin
               mlo = a / b;
               mhi = a % b;
            end
         end
         4'd4: mhi = a;
         4'd5: mlo = a;
`ifdef MDU_MADD_EN
         4'd6: {mhi, mlo} = acc + sp;
         4'd7: {mhi, mlo} = acc + up;
         4'd8: {mhi, mlo} = acc - sp;
         4'd9: {mhi, mlo} = acc - up;
`endif
         default: begin
         end
      endcase
   endfunction

   function automatic int cyclesFor(input logic [3:0] code);
      return (code == 4'd2 || code == 4'd3) ? DIVC : MULC;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h00000000;
         1: return 32'h00000001;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   // One-cycle start strobe, called at a negedge; operands scrambled afterwards
   task automatic applyStimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = code;
      op1   = a;
      op2   = b;
      @(negedge clk);
      start = 1'b0;
      op1   = $urandom;
      op2   = $urandom;
   endtask

   // Long op: busy for N cycles, then done pulse with hi/lo updated; optional intrusions while busy
   task automatic runLong(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, input bit intrude);
      int n;
      n = cyclesFor(code);
      applyStimulus(code, a, b);
      modelOp(code, a, b);
      for (int i = 0; i < n; i++) begin
         checkOutput("busy_high", 32'(busy), 32'd1);
         checkOutput("done_low", 32'(done), 32'd0);
         start = 1'b0;
         if (intrude && i == 1) begin
            start = 1'b1; op = 4'd4; op1 = $urandom;
         end else if (intrude && i == 2) begin
            start = 1'b1; op = 4'd0; op1 = $urandom; op2 = $urandom;
         end
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("busy_end", 32'(busy), 32'd0);
      checkOutput("hi", hi, mhi);
      checkOutput("lo", lo, mlo);
   endtask

   task automatic doMove(input logic [3:0] code, input logic [31:0] a);
      applyStimulus(code, a, $urandom);
      modelOp(code, a, 32'd0);
      checkOutput("move_busy", 32'(busy), 32'd0);
      checkOutput("move_done", 32'(done), 32'd0);
      checkOutput("move_hi", hi, mhi);
      checkOutput("move_lo", lo, mlo);
   endtask

   task automatic tryNoop(input logic [3:0] code);
      applyStimulus(code, $urandom, $urandom);
      modelOp(code, 32'd0, 32'd0);
      for (int i = 0; i < 2; i++) begin
         checkOutput("noop_busy", 32'(busy), 32'd0);
         checkOutput("noop_done", 32'(done), 32'd0);
         checkOutput("noop_hi", hi, mhi);
         checkOutput("noop_lo", lo, mlo);
         @(negedge clk);
      end
   endtask

   // Directed sequence followed by random traffic
   initial begin
      logic [31:0] a, b;
      int          sel;

      repeat (2) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_hi", hi, 32'd0);
      checkOutput("rst_lo", lo, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] multiply");
      runLong(4'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
      checkOutput("t1_mult_hi", hi, 32'hFFFFFFFF);
      checkOutput("t1_mult_lo", lo, 32'hFFFFFFF1);
      @(negedge clk);
      checkOutput("t1_done_once", 32'(done), 32'd0);
      runLong(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
      checkOutput("t1_multu_hi", hi, 32'h00000004);
      checkOutput("t1_multu_lo", lo, 32'hFFFFFFF1);

      $display("[TB] divide");
      runLong(4'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
      checkOutput("t2_div_lo", lo, 32'hFFFFFFFD);
      checkOutput("t2_div_hi", hi, 32'hFFFFFFFF);
      runLong(4'd3, 32'd7, 32'd2, 1'b0);
      checkOutput("t2_divu_lo", lo, 32'd3);
      checkOutput("t2_divu_hi", hi, 32'd1);

      $display("[TB] moves and divide by zero");
      doMove(4'd4, 32'h12345678);
      doMove(4'd5, 32'h9ABCDEF0);
      runLong(4'd3, 32'd5, 32'd0, 1'b0);
      checkOutput("t3_hi_kept", hi, 32'h12345678);
      checkOutput("t3_lo_kept", lo, 32'h9ABCDEF0);

      $display("[TB] signed overflow and back-to-back");
      runLong(4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      checkOutput("t4_ovf_lo", lo, 32'h80000000);
      checkOutput("t4_ovf_hi", hi, 32'd0);
      runLong(4'd0, 32'd6, 32'd7, 1'b0);
      checkOutput("t4_b2b_lo", lo, 32'd42);

      $display("[TB] start while busy");
      runLong(4'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1);

      $display("[TB] reset mid-divide");
      applyStimulus(4'd2, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      checkOutput("t6_busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_busy_rst", 32'(busy), 32'd0);
      checkOutput("t6_done_rst", 32'(done), 32'd0);
      checkOutput("t6_hi_rst", hi, 32'd0);
      checkOutput("t6_lo_rst", lo, 32'd0);
      mhi = '0;
      mlo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < DIVC + 3; i++) begin
         checkOutput("t6_no_done", 32'(done), 32'd0);
         checkOutput("t6_no_busy", 32'(busy), 32'd0);
         @(negedge clk);
      end
      checkOutput("t6_hi_after", hi, 32'd0);
      checkOutput("t6_lo_after", lo, 32'd0);

      $display("[TB] accumulate op 7");
      doMove(4'd4, 32'd0);
      doMove(4'd5, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
      runLong(4'd7, 32'd1, 32'd1, 1'b0);
      checkOutput("madd_hi", hi, 32'd1);
      checkOutput("madd_lo", lo, 32'd0);
`else
      tryNoop(4'd7);
      checkOutput("madd_off_hi", hi, 32'd0);
      checkOutput("madd_off_lo", lo, 32'hFFFFFFFF);
`endif

      $display("[TB] random traffic");
      for (int k = 0; k < 30; k++) begin
         sel = $urandom_range(0, 7);
         a   = pick();
         b   = pick();
         if (sel < 4)      runLong(4'(sel), a, b, 1'b0);
         else if (sel < 6) doMove(4'(sel), a);
         else              tryNoop(4'($urandom_range(10, 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
